// File: rtl/hwag_gen_pkg.sv
// hwag_gen_pkg: shared widths, clamp limits and FSM state type for the crank wheel generator
package hwag_gen_pkg;
  localparam int DEF_PW = 24;
  localparam int DEF_TW = 8;
  localparam int MIN_PERIOD = 2;
  localparam int MIN_TEETH = 3;
  typedef enum logic {GEN_IDLE, GEN_RUN} gen_state_t;
endpackage

// File: rtl/crank_slot_timer.sv
// crank_slot_timer: slot counter, period shadow, active-half compare and end-of-slot strobe
//   clk, rst          clock and synchronous active-high reset
//   start             first cycle of a run: clear counter, load period shadow
//   adv               running: advance counter, reload period shadow at slot end
//   period            requested slot length in clk cycles (clamped to >= 2 at load)
//   eos               current count is the last cycle of the slot
//   act_next          the count after the coming edge lies in the active half
module crank_slot_timer
  import hwag_gen_pkg::*;
#(
  parameter int PW = DEF_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          adv,
  input  logic [PW-1:0] period,
  output logic          eos,
  output logic          act_next
);
  logic [PW-1:0] cnt_q, cnt_d, per_q, per_d, per_c;
  always_comb begin
    per_c = period < PW'(MIN_PERIOD) ? PW'(MIN_PERIOD) : period;
    eos = cnt_q == per_q - PW'(1);
    cnt_d = start ? '0 : adv ? (eos ? '0 : cnt_q + PW'(1)) : cnt_q;
    per_d = (start || (adv && eos)) ? per_c : per_q;
    // odd periods leave the longer half inactive because of the floor
    act_next = cnt_d < (per_d >> 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end
endmodule

// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: synthetic missing-tooth crank wheel generator (optional cam via CRANK_WHEEL_GEN_CAM_EN)
//   clk, rst       clock and synchronous active-high reset
//   ena            run enable; dropping it stops immediately
//   inv            output polarity (1 = tooth low), shadowed per revolution
//   period         slot length in clk cycles, shadowed per slot
//   teeth_total    slots per revolution incl. missing, shadowed per revolution
//   teeth_missing  missing slots at end of revolution, shadowed per revolution
//   cam_tooth      (macro only) slot index of the cam pulse, shadowed per revolution
//   cam_out        (macro only) one-slot cam pulse every second revolution
//   vr_out         wheel signal; tooth_num slot index; gap missing slot;
//   rev_stb        first cycle of slot 0; busy running
module crank_wheel_gen
  import hwag_gen_pkg::*;
#(
  parameter int PW = DEF_PW,
  parameter int TW = DEF_TW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          inv,
  input  logic [PW-1:0] period,
  input  logic [TW-1:0] teeth_total,
  input  logic [1:0]    teeth_missing,
`ifdef CRANK_WHEEL_GEN_CAM_EN
  input  logic [TW-1:0] cam_tooth,
  output logic          cam_out,
`endif
  output logic          vr_out,
  output logic [TW-1:0] tooth_num,
  output logic          gap,
  output logic          rev_stb,
  output logic          busy
);
  gen_state_t state_q, state_d;
  logic [TW-1:0] idx_q, idx_d, total_q, total_d, tt_c;
  logic [1:0] missing_q, missing_d, ms_c;
  logic inv_q, inv_d;
  logic vr_out_q, vr_out_d, gap_q, gap_d, rev_stb_q, rev_stb_d, busy_q, busy_d;
  logic [TW-1:0] tooth_num_q, tooth_num_d;
  logic start, adv, eos, act_next, wrap, reload;
  crank_slot_timer #(.PW(PW)) u_timer (
    .clk(clk),
    .rst(rst),
    .start(start),
    .adv(adv),
    .period(period),
    .eos(eos),
    .act_next(act_next)
  );
  always_comb begin
    start = state_q == GEN_IDLE && ena;
    adv = state_q == GEN_RUN && ena;
    wrap = adv && eos && idx_q == total_q - TW'(1);
    reload = start || wrap;
    tt_c = teeth_total < TW'(MIN_TEETH) ? TW'(MIN_TEETH) : teeth_total;
    // keep at least two real teeth
    ms_c = TW'(teeth_missing) > tt_c - TW'(2) ? 2'(tt_c - TW'(2)) : teeth_missing;
    state_d = ena ? GEN_RUN : GEN_IDLE;
    total_d = reload ? tt_c : total_q;
    missing_d = reload ? ms_c : missing_q;
    inv_d = reload ? inv : inv_q;
    idx_d = reload ? '0 : (adv && eos) ? idx_q + TW'(1) : idx_q;
    gap_d = ena && idx_d >= total_d - TW'(missing_d);
    rev_stb_d = reload;
    busy_d = ena;
    tooth_num_d = ena ? idx_d : '0;
    vr_out_d = (ena && act_next && !gap_d) ? ~inv_d : inv_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GEN_IDLE;
      idx_q <= '0;
      total_q <= '0;
      missing_q <= '0;
      inv_q <= 1'b0;
      vr_out_q <= 1'b0;
      tooth_num_q <= '0;
      gap_q <= 1'b0;
      rev_stb_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      total_q <= total_d;
      missing_q <= missing_d;
      inv_q <= inv_d;
      vr_out_q <= vr_out_d;
      tooth_num_q <= tooth_num_d;
      gap_q <= gap_d;
      rev_stb_q <= rev_stb_d;
      busy_q <= busy_d;
    end
  end
  assign vr_out = vr_out_q;
  assign tooth_num = tooth_num_q;
  assign gap = gap_q;
  assign rev_stb = rev_stb_q;
  assign busy = busy_q;
`ifdef CRANK_WHEEL_GEN_CAM_EN
  logic phase_q, phase_d, cam_out_q, cam_out_d;
  logic [TW-1:0] cam_q, cam_d;
  always_comb begin
    cam_d = reload ? cam_tooth : cam_q;
    phase_d = !ena ? 1'b0 : rev_stb_d ? ~phase_q : phase_q;
    cam_out_d = ena && phase_d && idx_d == cam_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      cam_out_q <= 1'b0;
      cam_q <= '0;
    end else begin
      phase_q <= phase_d;
      cam_out_q <= cam_out_d;
      cam_q <= cam_d;
    end
  end
  assign cam_out = cam_out_q;
`endif
endmodule

// File: tb/tb_crank_wheel_gen.sv
// tb_crank_wheel_gen: directed and randomized checks of crank_wheel_gen against a slot-level model
module tb_crank_wheel_gen;
  localparam int PW = 24;
  localparam int TW = 8;
  logic clk = 1'b0;
  logic rst, ena, inv;
  logic [PW-1:0] period;
  logic [TW-1:0] teeth_total;
  logic [1:0] teeth_missing;
  logic vr_out, gap, rev_stb, busy;
  logic [TW-1:0] tooth_num;
`ifdef CRANK_WHEEL_GEN_CAM_EN
  logic [TW-1:0] cam_tooth;
  logic cam_out;
  int m_cam;
  bit m_phase;
`endif
  int total = 0, passed = 0, cyc = 0;
  bit m_run, m_inv, m_rev;
  int m_len, m_tot, m_mis, m_pos, m_idx;
  crank_wheel_gen #(.PW(PW), .TW(TW)) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .inv(inv),
    .period(period),
    .teeth_total(teeth_total),
    .teeth_missing(teeth_missing),
`ifdef CRANK_WHEEL_GEN_CAM_EN
    .cam_tooth(cam_tooth),
    .cam_out(cam_out),
`endif
    .vr_out(vr_out),
    .tooth_num(tooth_num),
    .gap(gap),
    .rev_stb(rev_stb),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask
  task automatic load_rev();
    m_tot = teeth_total < 3 ? 3 : int'(teeth_total);
    m_mis = int'(teeth_missing) > m_tot - 2 ? m_tot - 2 : int'(teeth_missing);
    m_inv = inv;
`ifdef CRANK_WHEEL_GEN_CAM_EN
    m_cam = cam_tooth;
`endif
  endtask
  task automatic tick();
    int len_next;
    len_next = period < 2 ? 2 : int'(period);
    if (rst) begin
      m_run = 0; m_inv = 0; m_rev = 0; m_idx = 0; m_pos = 0;
`ifdef CRANK_WHEEL_GEN_CAM_EN
      m_phase = 0;
`endif
    end else if (!ena) begin
      m_run = 0; m_rev = 0;
`ifdef CRANK_WHEEL_GEN_CAM_EN
      m_phase = 0;
`endif
    end else if (!m_run) begin
      m_run = 1; m_pos = 0; m_idx = 0; m_len = len_next; m_rev = 1;
      load_rev();
    end else begin
      m_rev = 0;
      m_pos++;
      if (m_pos == m_len) begin
        m_pos = 0;
        m_len = len_next;
        m_idx++;
        if (m_idx == m_tot) begin
          m_idx = 0;
          m_rev = 1;
          load_rev();
        end
      end
    end
`ifdef CRANK_WHEEL_GEN_CAM_EN
    if (m_rev) m_phase = !m_phase;
`endif
    @(posedge clk);
    #1;
    cyc++;
    chk("busy", busy, m_run);
    chk("rev_stb", rev_stb, m_rev);
    chk("tooth_num", tooth_num, m_run ? m_idx : 0);
    chk("gap", gap, m_run && m_idx >= m_tot - m_mis);
    chk("vr_out", vr_out, (m_run && m_pos < m_len / 2 && m_idx < m_tot - m_mis) ? !m_inv : m_inv);
`ifdef CRANK_WHEEL_GEN_CAM_EN
    chk("cam_out", cam_out, m_run && m_phase && m_idx == m_cam);
`endif
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic run_rev(input int n, input int rev_period);
    int last;
    last = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rev_stb) begin
        if (last >= 0) chk("rev_interval", cyc - last, rev_period);
        last = cyc;
      end
    end
  endtask
  task automatic setup(input int p, input int tt, input int ms, input bit iv);
    period = PW'(p);
    teeth_total = TW'(tt);
    teeth_missing = 2'(ms);
    inv = iv;
  endtask
  initial begin
    rst = 1; ena = 0;
    setup(10, 6, 0, 0);
`ifdef CRANK_WHEEL_GEN_CAM_EN
    cam_tooth = 2;
`endif
    ticks(3);
    rst = 0;
    ticks(2);
    ena = 1;
    run_rev(130, 60);
    ena = 0;
    ticks(2);
    setup(8, 6, 2, 0);
    ena = 1;
    run_rev(110, 48);
    ena = 0;
    ticks(1);
    setup(1, 2, 3, 0);
    ena = 1;
    run_rev(20, 6);
    ena = 0;
    ticks(1);
    setup(10, 6, 0, 0);
    ena = 1;
    ticks(3);
    period = 6;
    ticks(40);
    teeth_total = 4;
    ticks(80);
    ena = 0;
    ticks(1);
    period = 10;
    ena = 1;
    ticks(4);
    ena = 0;
    ticks(1);
    chk("stop_vr_out", vr_out, 0);
    ticks(1);
    setup(7, 5, 1, 1);
`ifdef CRANK_WHEEL_GEN_CAM_EN
    cam_tooth = 2;
    setup(4, 6, 0, 0);
`endif
    ena = 1;
    ticks(60);
    inv = 1;
    ticks(30);
    rst = 1;
    ticks(1);
    chk("rst_vr_out", vr_out, 0);
    rst = 0; ena = 0;
    ticks(1);
    for (int s = 0; s < 40; s++) begin
      setup($urandom_range(1, 12), $urandom_range(0, 9), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
`ifdef CRANK_WHEEL_GEN_CAM_EN
      cam_tooth = TW'($urandom_range(0, 8));
`endif
      ena = ($urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 30) == 0);
      for (int i = 0; i < int'($urandom_range(5, 40)); i++) begin
        tick();
        rst = 0;
        if ($urandom_range(0, 9) == 0) period = PW'($urandom_range(1, 12));
        if ($urandom_range(0, 19) == 0) teeth_total = TW'($urandom_range(0, 9));
        if ($urandom_range(0, 19) == 0) teeth_missing = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) inv = ~inv;
        if ($urandom_range(0, 49) == 0) ena = ~ena;
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/crank_wheel_gen.md
Name: crank_wheel_gen

Overview:
Synthetic trigger-wheel (crank) signal generator: the transmit-side counterpart of the angle generator's VR input chain. It produces a square tooth train with a configurable number of teeth, a missing-tooth gap and a tooth period in clock cycles. It feeds bench and in-system self-test through the capture/filter input, exercising period capture, min/max checks and gap search. It is a standalone module, configured from registers in the same register space.

Parameters:
PW, 24, tooth period counter width (matches the period counter width)
TW, 8, tooth index / tooth count width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high; single clock domain (clk)
ena  in  1  run enable; 0 = idle, 1 = generate
inv  in  1  output polarity; 0 = tooth high, 1 = tooth low
period  in  PW  tooth slot length in clk cycles
teeth_total  in  TW  physical tooth slots per revolution, including missing slots
teeth_missing  in  2  missing teeth at end of revolution, 0..3
vr_out  out  1  generated wheel signal
tooth_num  out  TW  current slot index, 0..teeth_total-1
gap  out  1  high while current slot is a missing slot
rev_stb  out  1  one-cycle pulse at start of slot 0
busy  out  1  high in RUN state

Behaviour:
- Reset values: vr_out=inv_reg (0 after reset), tooth_num=0, gap=0, rev_stb=0, busy=0; state IDLE; shadow registers cleared.
- All outputs are registered.
- States: IDLE, RUN.
- IDLE->RUN: when ena=1. In that cycle, load the shadows (period_s, total_s, missing_s, inv_s) and clear the slot counter and tooth index.
- RUN->IDLE: when ena=0. This is immediate and takes effect mid-tooth. The next cycle returns all outputs to reset values, except vr_out, which equals the inactive level of inv_s.
- Latency: ena rises in cycle N, registered at edge N+1. vr_out goes active, rev_stb=1, busy=1 and tooth_num=0 are all visible after edge N+1.
- Slot timing:
  - Slot counter runs 0..period_s-1.
  - Tooth is active for counts 0..(period_s>>1)-1 and inactive for the rest.
  - For odd periods, the low half is the longer one.
- Missing slots: index >= total_s-missing_s. In these slots vr_out stays inactive for the whole slot and gap=1.
- Wrap: at counter = period_s-1, the counter goes to 0 and the index increments. At index = total_s-1, the index goes to 0 and rev_stb pulses with the first cycle of slot 0.
- Shadow reload:
  - period_s reloads at every slot boundary, so the period can change per tooth.
  - total_s, missing_s and inv_s reload only at the revolution boundary (index wrap), so the gap geometry is never torn mid-revolution.
- Clamping, applied at load:
  - period<2 is treated as 2.
  - teeth_total<3 is treated as 3.
  - missing is clamped to teeth_total-2, so at least two real teeth always remain.
- Simultaneous events:
  - rst has priority over everything.
  - ena falling in the same cycle as a wrap: IDLE wins, and rev_stb is not asserted.
- Counter arithmetic is unsigned, width PW. No overflow is possible because the counter is compared against period_s-1.

Optional Feature:
- Macro: CRANK_WHEEL_GEN_CAM_EN.
- When defined:
  - Adds output cam_out (1 bit, reset 0) and input cam_tooth (TW bits).
  - A phase flip-flop toggles on each rev_stb (reset 0).
  - cam_out is high for exactly one full slot: the slot where tooth_num==cam_tooth and phase==1. This gives one cam pulse per two revolutions.
  - cam_tooth is reloaded with total_s.
- When not defined: no port and no logic are added; behaviour is otherwise identical.

Decomposition:
- Package hwag_gen_pkg:
  - localparams for the default PW/TW;
  - enum gen_state_t {GEN_IDLE, GEN_RUN};
  - constants MIN_PERIOD=2, MIN_TEETH=3.
- One sub-module, crank_slot_timer: slot counter, period shadow, active-half compare and end-of-slot strobe. The top level holds the FSM, tooth index, gap logic and the optional cam logic.

Test Plan:
- Basic tooth train: period=10, teeth_total=6, missing=0, inv=0, ena raised.
  - Expect vr_out high 5 cycles, low 5 cycles, repeating.
  - Expect rev_stb every 60 cycles; tooth_num steps 0..5.
- Missing teeth: period=8, teeth_total=6, missing=2.
  - Expect 4 teeth of 4 high/4 low, then 16 cycles low with gap=1 and tooth_num 4,5.
  - Expect rev_stb period 48.
- Clamping: period=1, teeth_total=2, missing=3.
  - Expect a 2-cycle slot (1 high, 1 low) and 3 slots per revolution.
  - Expect exactly 1 missing slot; rev_stb every 6 cycles.
- Reload timing:
  - Change period 10->6 mid-slot: the new length applies from the next slot boundary.
  - Change teeth_total mid-revolution: the change takes effect only after the next rev_stb.
- Stop and reset:
  - Drop ena at cycle 3 of a tooth: next cycle busy=0, tooth_num=0, vr_out=0.
  - Assert rst during RUN with inv=1: all outputs return to reset values (vr_out=0).
- CAM (macro defined): teeth_total=6, cam_tooth=2, period=4.
  - Expect cam_out high for 4 cycles coinciding with tooth_num=2 in every second revolution only.
